// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: controller states, register-address width
// and the hardwired zero-register number.
package hazard_ctrl_pkg;

    localparam int PIPE_REG_W = 5;

    localparam logic [PIPE_REG_W-1:0] ZERO_REG = '0;

    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2,
        ERROR  = 2'd3
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Combinational hazard decode: register dependence between the ID and EX
// instructions, load-use, branch-on-ALU-result, branch-on-load and
// data-memory wait conditions.
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = PIPE_REG_W
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             lu,
    output logic             bd,
    output logic             blu,
    output logic             mw
);

    logic dep;

    // Register zero never carries a real dependence, so it is excluded.
    always_comb begin
        dep = (ex_rd != REG_W'(ZERO_REG)) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        lu  = ex_mem_read && dep;
        bd  = id_branch && ex_reg_write && !ex_mem_read && dep;
        blu = id_branch && lu;
        mw  = dmem_req && !dmem_ack;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze sequencing FSM with a
// memory-wait timeout. Optional statistics counters are compiled in when
// HAZARD_STATS_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W    = PIPE_REG_W,
    parameter int WAIT_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             id_br_taken,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             err
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt,
    output logic [STAT_W-1:0] freeze_cnt
`endif
);

    localparam int              WAIT_W    = $clog2(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT  = '1;

    logic rst_meta;
    logic rst_sync_n;

    logic lu, bd, blu, mw;

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [1:0]        stall_q, stall_d;
    logic              run_eval;

    logic pc_write_c, if_id_write_c, flush_c, bubble_c, freeze_c;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_branch    (id_branch),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .lu           (lu),
        .bd           (bd),
        .blu          (blu),
        .mw           (mw)
    );

    // Reset asserts immediately but is released only on a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    // Next-state and output decode; the ack cycle of FREEZE reuses RUN decisions.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        stall_d       = stall_q;
        run_eval      = 1'b0;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        flush_c       = 1'b0;
        bubble_c      = 1'b0;
        freeze_c      = 1'b0;
        wait_inc      = (wait_q == WAIT_SAT) ? wait_q : wait_q + 1'b1;

        case (state_q)
            RUN: run_eval = 1'b1;
            STALL: begin
                if (mw) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    freeze_c      = 1'b1;
                    wait_d        = '0;
                    stall_d       = '0;
                    state_d       = FREEZE;
                end else begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    bubble_c      = 1'b1;
                    if (stall_q <= 2'd1) begin
                        stall_d = '0;
                        state_d = RUN;
                    end else begin
                        stall_d = stall_q - 1'b1;
                    end
                end
            end
            FREEZE: begin
                if (dmem_ack) begin
                    run_eval = 1'b1;
                end else begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    freeze_c      = 1'b1;
                    wait_d        = wait_inc;
                    if (wait_inc == WAIT_LAST) begin
                        state_d = ERROR;
                    end
                end
            end
            ERROR: begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                freeze_c      = 1'b1;
            end
            default: state_d = RUN;
        endcase

        if (run_eval) begin
            state_d = RUN;
            if (mw) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                freeze_c      = 1'b1;
                wait_d        = '0;
                state_d       = FREEZE;
            end else if (blu) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                bubble_c      = 1'b1;
                stall_d       = 2'd1;
                state_d       = STALL;
            end else if (lu || bd) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                bubble_c      = 1'b1;
            end else if (id_br_taken) begin
                flush_c = 1'b1;
            end
        end
    end

    // Every control output is held low while reset is in effect.
    always_comb begin
        pc_write     = rst_sync_n && pc_write_c;
        if_id_write  = rst_sync_n && if_id_write_c;
        if_id_flush  = rst_sync_n && flush_c;
        id_ex_bubble = rst_sync_n && bubble_c;
        pipe_freeze  = rst_sync_n && freeze_c;
        err          = rst_sync_n && (state_q == ERROR);
    end

`ifdef HAZARD_STATS_EN
    // Saturating event counters for stall, flush and FREEZE cycles.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (bubble_c && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_c && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if ((state_q == FREEZE) && (freeze_cnt != '1)) begin
                freeze_cnt <= freeze_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes reference-model
// expectations into a queue, a monitor pops and compares every cycle.
module tb_hazard_ctrl;

    localparam int REG_W    = 5;
    localparam int WAIT_MAX = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic             id_uses_rt = 1'b0, id_branch = 1'b0, id_br_taken = 1'b0;
    logic             ex_mem_read = 1'b0, ex_reg_write = 1'b0;
    logic             dmem_req = 1'b0, dmem_ack = 1'b0;
    logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, err;
`ifdef HAZARD_STATS_EN
    logic [15:0]      stall_cnt, flush_cnt, freeze_cnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_branch    (id_branch),
        .id_br_taken  (id_br_taken),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .dmem_req     (dmem_req),
        .dmem_ack     (dmem_ack),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .pipe_freeze  (pipe_freeze),
        .err          (err)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .freeze_cnt   (freeze_cnt)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       branch;
        logic       br;
        logic       mr;
        logic       rw;
        logic [4:0] rd;
        logic       req;
        logic       ack;
    } stim_t;

    // outs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, err}
    typedef struct packed {
        logic [5:0]  outs;
        logic [15:0] st;
        logic [15:0] fl;
        logic [15:0] fr;
    } exp_t;

    localparam logic [5:0] O_RUN    = 6'b110000;
    localparam logic [5:0] O_FLUSH  = 6'b111000;
    localparam logic [5:0] O_STALL  = 6'b000100;
    localparam logic [5:0] O_FREEZE = 6'b000010;
    localparam logic [5:0] O_ERROR  = 6'b000011;
    localparam logic [5:0] O_RESET  = 6'b000000;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state, phrased as "what the pipeline is doing".
    bit m_frozen;
    bit m_error;
    int m_freeze_run;
    int m_stall_left;
    int m_hold;
    int m_st, m_fl, m_fr;

    function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt, input logic branch, input logic br,
                                 input logic mr, input logic rw, input logic [4:0] rd,
                                 input logic req, input logic ack);
        stim_t s;
        s.rst = 1'b1; s.rs = rs; s.rt = rt; s.uses_rt = uses_rt; s.branch = branch;
        s.br = br; s.mr = mr; s.rw = rw; s.rd = rd; s.req = req; s.ack = ack;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst     = ($urandom_range(0, 99) != 0);
        s.rs      = 5'($urandom_range(0, 3));
        s.rt      = 5'($urandom_range(0, 3));
        s.uses_rt = 1'($urandom_range(0, 1));
        s.branch  = ($urandom_range(0, 2) == 0);
        s.br      = ($urandom_range(0, 2) == 0);
        s.mr      = ($urandom_range(0, 2) == 0);
        s.rw      = 1'($urandom_range(0, 1));
        s.rd      = 5'($urandom_range(0, 3));
        s.req     = ($urandom_range(0, 5) == 0);
        s.ack     = ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    task automatic modelStep(input stim_t s, output exp_t e);
        bit dep, lu, bd, blu, mw, was_frozen;
        e = '0;
        if (!s.rst) begin
            m_frozen = 0; m_error = 0; m_freeze_run = 0; m_stall_left = 0;
            m_st = 0; m_fl = 0; m_fr = 0; m_hold = 2;
            e.outs = O_RESET;
            return;
        end
        e.st = 16'(m_st); e.fl = 16'(m_fl); e.fr = 16'(m_fr);
        if (m_hold > 0) begin
            m_hold--;
            e.outs = O_RESET;
            return;
        end
        dep = (s.rd != 0) && ((s.rd == s.rs) || (s.uses_rt && s.rd == s.rt));
        lu  = s.mr && dep;
        bd  = s.branch && s.rw && !s.mr && dep;
        blu = s.branch && lu;
        mw  = s.req && !s.ack;
        was_frozen = m_frozen;
        if (m_error) begin
            e.outs = O_ERROR;
        end else if (m_frozen && !s.ack) begin
            e.outs = O_FREEZE;
            m_freeze_run++;
            if (m_freeze_run == WAIT_MAX) begin
                m_error  = 1;
                m_frozen = 0;
            end
        end else begin
            m_frozen = 0;
            if (m_stall_left > 0 && mw) begin
                e.outs = O_FREEZE; m_frozen = 1; m_freeze_run = 1; m_stall_left = 0;
            end else if (m_stall_left > 0) begin
                e.outs = O_STALL; m_stall_left--;
            end else if (mw) begin
                e.outs = O_FREEZE; m_frozen = 1; m_freeze_run = 1;
            end else if (blu) begin
                e.outs = O_STALL; m_stall_left = 1;
            end else if (lu || bd) begin
                e.outs = O_STALL;
            end else if (s.br) begin
                e.outs = O_FLUSH;
            end else begin
                e.outs = O_RUN;
            end
        end
        if (e.outs[2] && m_st < 65535) m_st++;
        if (e.outs[3] && m_fl < 65535) m_fl++;
        if (was_frozen && m_fr < 65535) m_fr++;
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = s.rst;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_uses_rt   = s.uses_rt;
        id_branch    = s.branch;
        id_br_taken  = s.br;
        ex_mem_read  = s.mr;
        ex_reg_write = s.rw;
        ex_rd        = s.rd;
        dmem_req     = s.req;
        dmem_ack     = s.ack;
        modelStep(s, e);
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [5:0] act;
        act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, err};
        vectors++;
        if (act !== e.outs) begin
            miscompares++;
            $display("[TB] FAIL outputs t=%0t actual(pc,ifid,flush,bubble,freeze,err)=%b required=%b",
                     $time, act, e.outs);
        end
`ifdef HAZARD_STATS_EN
        vectors++;
        if ({stall_cnt, flush_cnt, freeze_cnt} !== {e.st, e.fl, e.fr}) begin
            miscompares++;
            $display("[TB] FAIL stats t=%0t actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                     $time, stall_cnt, flush_cnt, freeze_cnt, e.st, e.fl, e.fr);
        end
`endif
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1'b0;
        applyStimulus(s); applyStimulus(s);
        repeat (4) applyStimulus(idle());

        // load-use, then idle
        applyStimulus(mk(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0));
        repeat (2) applyStimulus(idle());
        // zero register never stalls
        applyStimulus(mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0));
        // rt match ignored when rt is not read
        applyStimulus(mk(5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0));
        // branch on ALU result then taken flush
        applyStimulus(mk(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0));
        applyStimulus(mk(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
        // branch on load: two stall cycles then flush
        applyStimulus(mk(5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0));
        repeat (2) applyStimulus(mk(5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
        applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
        // memory wait acked after three freeze cycles
        repeat (3) applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
        applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1));
        applyStimulus(idle());
        // memory wait arriving during a branch-on-load stall
        applyStimulus(mk(5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0));
        applyStimulus(mk(5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
        applyStimulus(mk(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1));
        applyStimulus(idle());
        // reset in the middle of a stall
        applyStimulus(mk(5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0));
        s = idle(); s.rst = 1'b0;
        applyStimulus(s); applyStimulus(s);
        repeat (3) applyStimulus(idle());

        // randomized traffic
        for (int i = 0; i < 400; i++) applyStimulus(rnd());
        s = idle(); s.rst = 1'b0;
        applyStimulus(s);
        repeat (3) applyStimulus(idle());

        // memory never answers: timeout, sticky error, then reset
        repeat (20) applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0));
        for (int i = 0; i < 6; i++) begin
            s = rnd(); s.rst = 1'b1;
            applyStimulus(s);
        end
        s = idle(); s.rst = 1'b0;
        applyStimulus(s); applyStimulus(s);
        repeat (4) applyStimulus(idle());

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
